// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: byte handshake from the UART receiver (master) to its consumer (slave); rdata/rvalid/rready plus frame_err/overrun pulses
interface uart_rx_byte_if;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       frame_err;
  logic       overrun;
  modport master(output rdata, rvalid, frame_err, overrun, input rready);
  modport slave(input rdata, rvalid, frame_err, overrun, output rready);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver; CLK/RST_N (sync, active-low), UART_RX serial in, bus = byte holding register with frame_err/overrun pulses
module uart_rx_byte #(
  parameter int CLK_PER_BIT = 868,
  parameter int HALF_BIT    = CLK_PER_BIT / 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           UART_RX,
  uart_rx_byte_if.master bus
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_m, rx_s;
  // dlv marks the cycle after a good stop sample, when the byte is offered to the holding register
  logic          dlv;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      dlv           <= 1'b0;
      bus.rdata     <= '0;
      bus.rvalid    <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      rx_m          <= UART_RX;
      rx_s          <= rx_m;
      dlv           <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (dlv && (!bus.rvalid || bus.rready)) begin
        bus.rdata  <= shift;
        bus.rvalid <= 1'b1;
      end else if (dlv) bus.overrun <= 1'b1;
      else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          bit_cnt <= '0;
        end
        START: if (bit_cnt == HALF_END) begin
          state   <= rx_s ? IDLE : DATA;
          bit_cnt <= '0;
          bit_idx <= '0;
        end else bit_cnt <= bit_cnt + 1'b1;
        DATA: if (bit_cnt == BIT_END) begin
          shift[bit_idx] <= rx_s;
          bit_cnt        <= '0;
          bit_idx        <= bit_idx + 1'b1;
          state          <= (bit_idx == 3'd7) ? STOP : DATA;
        end else bit_cnt <= bit_cnt + 1'b1;
        // returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge
        STOP: if (bit_cnt == BIT_END) begin
          bit_cnt       <= '0;
          state         <= rx_s ? IDLE : BRK;
          dlv           <= rx_s;
          bus.frame_err <= !rx_s;
        end else bit_cnt <= bit_cnt + 1'b1;
        // a held-low line must go high before another start can be recognised
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed table-driven bench for uart_rx_byte at 16 clocks per bit
module tb_uart_rx_byte;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         exp_rv;
    int         exp_fe;
    logic [7:0] exp_rdata;
    bit         chk_lat;
  } vec_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic UART_RX = 1'b1;
  uart_rx_byte_if bus();
  uart_rx_byte #(.CLK_PER_BIT(CPB)) dut (.CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX), .bus(bus));
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int n_tests = 0, n_fail = 0;
  int rv_hi = 0, rv_rise = 0, fe_n = 0, ov_n = 0, both_n = 0;
  int rise_cyc [0:7];
  logic [7:0] rise_data [0:7];
  logic rv_q = 1'b0;
  int fall_cyc = 0;
  always @(negedge CLK) begin
    if (bus.rvalid === 1'b1) rv_hi++;
    if (bus.rvalid === 1'b1 && !rv_q) begin
      if (rv_rise < 8) begin
        rise_cyc[rv_rise]  = cyc;
        rise_data[rv_rise] = bus.rdata;
      end
      rv_rise++;
    end
    rv_q = (bus.rvalid === 1'b1);
    if (bus.frame_err === 1'b1) fe_n++;
    if (bus.overrun === 1'b1) ov_n++;
    if (bus.frame_err === 1'b1 && bus.overrun === 1'b1) both_n++;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic clr();
    rv_hi = 0; rv_rise = 0; fe_n = 0; ov_n = 0;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic drive_bit(input logic b);
    UART_RX = b;
    wait_cyc(CPB);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop);
    UART_RX = 1'b0;
    fall_cyc = cyc;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask
  vec_t vecs [0:3];
  initial begin
    vecs[0] = '{8'h55, 1'b1, 0,  1, 0, 8'h55, 1'b1};
    vecs[1] = '{8'hA3, 1'b0, 40, 0, 1, 8'h55, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 0,  1, 0, 8'h3C, 1'b1};
    vecs[3] = '{8'hC1, 1'b1, 0,  1, 0, 8'hC1, 1'b1};
    bus.rready = 1'b1;
    wait_cyc(3);
    chk("reset_rdata", int'(bus.rdata), 0);
    chk("reset_rvalid", int'(bus.rvalid), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_overrun", int'(bus.overrun), 0);
    RST_N = 1'b1;
    wait_cyc(5);
    for (int v = 0; v < 4; v++) begin
      clr();
      send_byte(vecs[v].data, vecs[v].stop);
      if (vecs[v].hold_low > 0) begin
        UART_RX = 1'b0;
        wait_cyc(vecs[v].hold_low);
      end
      UART_RX = 1'b1;
      wait_cyc(20);
      chk($sformatf("vec%0d_rvalid_pulses", v), rv_rise, vecs[v].exp_rv);
      chk($sformatf("vec%0d_rvalid_cycles", v), rv_hi, vecs[v].exp_rv);
      chk($sformatf("vec%0d_frame_err", v), fe_n, vecs[v].exp_fe);
      chk($sformatf("vec%0d_overrun", v), ov_n, 0);
      chk($sformatf("vec%0d_rdata", v), int'(bus.rdata), int'(vecs[v].exp_rdata));
      if (vecs[v].chk_lat)
        chk_rng($sformatf("vec%0d_latency", v), rise_cyc[0] - fall_cyc, 154, 156);
    end
    clr();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h80, 1'b1);
    wait_cyc(20);
    chk("b2b_pulses", rv_rise, 3);
    chk("b2b_data0", int'(rise_data[0]), 8'h00);
    chk("b2b_data1", int'(rise_data[1]), 8'hFF);
    chk("b2b_data2", int'(rise_data[2]), 8'h80);
    chk("b2b_gap01", rise_cyc[1] - rise_cyc[0], 160);
    chk("b2b_gap12", rise_cyc[2] - rise_cyc[1], 160);
    chk("b2b_frame_err", fe_n, 0);
    clr();
    UART_RX = 1'b0;
    wait_cyc(4);
    UART_RX = 1'b1;
    wait_cyc(40);
    chk("glitch_rvalid", rv_rise, 0);
    chk("glitch_frame_err", fe_n, 0);
    send_byte(8'hA7, 1'b1);
    wait_cyc(20);
    chk("after_glitch_pulses", rv_rise, 1);
    chk("after_glitch_rdata", int'(bus.rdata), 8'hA7);
    clr();
    bus.rready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_cyc(20);
    chk("ovr_rvalid", int'(bus.rvalid), 1);
    chk("ovr_rdata", int'(bus.rdata), 8'h11);
    chk("ovr_pulses", ov_n, 1);
    chk("ovr_rise", rv_rise, 1);
    bus.rready = 1'b1;
    wait_cyc(1);
    bus.rready = 1'b0;
    chk("ovr_consumed_rvalid", int'(bus.rvalid), 0);
    chk("ovr_consumed_rdata", int'(bus.rdata), 8'h11);
    bus.rready = 1'b1;
    wait_cyc(5);
    clr();
    UART_RX = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h96 >> i));
    UART_RX = 1'b1;
    wait_cyc(8);
    RST_N = 1'b0;
    wait_cyc(1);
    chk("rst_mid_rdata", int'(bus.rdata), 0);
    chk("rst_mid_rvalid", int'(bus.rvalid), 0);
    chk("rst_mid_frame_err", int'(bus.frame_err), 0);
    chk("rst_mid_overrun", int'(bus.overrun), 0);
    RST_N = 1'b1;
    wait_cyc(200);
    chk("rst_mid_no_rvalid", rv_rise, 0);
    send_byte(8'h69, 1'b1);
    wait_cyc(20);
    chk("after_rst_pulses", rv_rise, 1);
    chk("after_rst_rdata", int'(bus.rdata), 8'h69);
    chk("never_both_pulses", both_n, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
